// File: rtl/vga_timing_if.sv
// vga_timing_if: video timing bus between the timing generator and the draw stages.
//   hcount/vcount : current column / line (11-bit)
//   hsync/vsync   : active-high sync strobes
//   hblnk/vblnk   : blanking strobes
//   frame_start   : one-clock pulse on wrap to (0,0)
//   frame_cnt     : frames completed since reset (wraps at 2^16)
// master drives the bus (vga_timing); slave consumes it (draw stages).
interface vga_timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running 1024x768@60 VGA timing generator (65 MHz pixel clock).
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   o_vga : timing bus (master) -- counters, sync/blank strobes, frame tick, frame count
// Every bus output is a flop. Strobes are decoded from the next-state counters so they
// line up with the counter value they describe. All parameters must be < 2048.
module vga_timing #(
  parameter int unsigned H_TOTAL       = 1344,
  parameter int unsigned H_BLANK_START = 1024,
  parameter int unsigned H_SYNC_START  = 1048,
  parameter int unsigned H_SYNC_END    = 1184,
  parameter int unsigned V_TOTAL       = 806,
  parameter int unsigned V_BLANK_START = 768,
  parameter int unsigned V_SYNC_START  = 771,
  parameter int unsigned V_SYNC_END    = 777
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_timing_if.master  o_vga
);

  localparam logic [10:0] LP_H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] LP_V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] LP_H_BLANK = 11'(H_BLANK_START);
  localparam logic [10:0] LP_H_SYNC0 = 11'(H_SYNC_START);
  localparam logic [10:0] LP_H_SYNC1 = 11'(H_SYNC_END);
  localparam logic [10:0] LP_V_BLANK = 11'(V_BLANK_START);
  localparam logic [10:0] LP_V_SYNC0 = 11'(V_SYNC_START);
  localparam logic [10:0] LP_V_SYNC1 = 11'(V_SYNC_END);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;
  logic        r_frame_start;
  logic [15:0] r_frame_cnt;

  logic        w_h_wrap;
  logic        w_v_last;
  logic        w_frame_wrap;
  logic [10:0] w_hcount_d;
  logic [10:0] w_vcount_d;
  logic        w_hsync_d;
  logic        w_vsync_d;
  logic        w_hblnk_d;
  logic        w_vblnk_d;

  always_comb begin
    w_h_wrap     = (r_hcount == LP_H_LAST);
    w_v_last     = (r_vcount == LP_V_LAST);
    w_frame_wrap = w_h_wrap && w_v_last;

    w_hcount_d = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_vcount_d = r_vcount;
    if (w_h_wrap) begin
      w_vcount_d = w_v_last ? 11'd0 : r_vcount + 11'd1;
    end

    // Decode on the values the counters take at the coming edge: zero skew.
    w_hblnk_d = (w_hcount_d >= LP_H_BLANK);
    w_hsync_d = (w_hcount_d >= LP_H_SYNC0) && (w_hcount_d < LP_H_SYNC1);
    w_vblnk_d = (w_vcount_d >= LP_V_BLANK);
    w_vsync_d = (w_vcount_d >= LP_V_SYNC0) && (w_vcount_d < LP_V_SYNC1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      r_hcount      <= w_hcount_d;
      r_vcount      <= w_vcount_d;
      r_hsync       <= w_hsync_d;
      r_vsync       <= w_vsync_d;
      r_hblnk       <= w_hblnk_d;
      r_vblnk       <= w_vblnk_d;
      // Only a real wrap pulses; leaving reset at (0,0) does not.
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_vga.hcount      = r_hcount;
  assign o_vga.vcount      = r_vcount;
  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.hblnk       = r_hblnk;
  assign o_vga.vblnk       = r_vblnk;
  assign o_vga.frame_start = r_frame_start;
  assign o_vga.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of vga_timing.
// dut_s uses a scaled-down geometry so whole frames fit in a short run; dut_f uses the
// default 1024x768 geometry and is checked over the first six lines.
module tb_vga_timing;

  // Scaled geometry for dut_s.
  localparam int HT = 20, HB = 12, HS = 14, HE = 17;
  localparam int VT = 10, VB = 6, VS = 7, VE = 9;
  localparam int FRAME = HT * VT;
  // Full geometry for dut_f.
  localparam int FHT = 1344, FHB = 1024, FHS = 1048, FHE = 1184;
  localparam int N_MAIN = 6 * FHT + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_if vga_s ();
  vga_timing_if vga_f ();

  vga_timing #(
    .H_TOTAL(HT), .H_BLANK_START(HB), .H_SYNC_START(HS), .H_SYNC_END(HE),
    .V_TOTAL(VT), .V_BLANK_START(VB), .V_SYNC_START(VS), .V_SYNC_END(VE)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .o_vga (vga_s)
  );

  vga_timing dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .o_vga (vga_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hcount"}, 32'(vga_s.hcount), 0);
    check({tag, "_vcount"}, 32'(vga_s.vcount), 0);
    check({tag, "_hsync"},  32'(vga_s.hsync), 0);
    check({tag, "_vsync"},  32'(vga_s.vsync), 0);
    check({tag, "_hblnk"},  32'(vga_s.hblnk), 0);
    check({tag, "_vblnk"},  32'(vga_s.vblnk), 0);
    check({tag, "_fstart"}, 32'(vga_s.frame_start), 0);
    check({tag, "_fcnt"},   32'(vga_s.frame_cnt), 0);
  endtask

  initial begin
    int h, v, last_pulse, pulses;
    bit found;

    // Reset held for 5 clocks.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("rst");
    check("rst_f_hcount", 32'(vga_f.hcount), 0);
    check("rst_f_hsync", 32'(vga_f.hsync), 0);

    // Release on a falling edge; n counts rising edges since release.
    rst_n = 1'b1;
    last_pulse = 0;
    pulses = 0;
    for (int n = 1; n <= N_MAIN; n++) begin
      @(negedge clk);
      h = n % HT;
      v = (n / HT) % VT;
      check("s_hcount", 32'(vga_s.hcount), 32'(h));
      check("s_vcount", 32'(vga_s.vcount), 32'(v));
      check("s_hblnk",  32'(vga_s.hblnk), 32'(h >= HB));
      check("s_hsync",  32'(vga_s.hsync), 32'(h >= HS && h < HE));
      check("s_vblnk",  32'(vga_s.vblnk), 32'(v >= VB));
      check("s_vsync",  32'(vga_s.vsync), 32'(v >= VS && v < VE));
      check("s_fstart", 32'(vga_s.frame_start), 32'((n % FRAME) == 0));
      check("s_fcnt",   32'(vga_s.frame_cnt), 32'(n / FRAME));
      if (vga_s.frame_start && pulses < 3) begin
        pulses++;
        check("s_spacing", 32'(n - last_pulse), 32'(FRAME));
        last_pulse = n;
        if (pulses == 3) check("s_fcnt3", 32'(vga_s.frame_cnt), 3);
      end
      h = n % FHT;
      v = n / FHT;
      check("f_hcount", 32'(vga_f.hcount), 32'(h));
      check("f_vcount", 32'(vga_f.vcount), 32'(v));
      check("f_hblnk",  32'(vga_f.hblnk), 32'(h >= FHB));
      check("f_hsync",  32'(vga_f.hsync), 32'(h >= FHS && h < FHE));
      if (n == 1) begin
        check("first_f_hcount", 32'(vga_f.hcount), 1);
        check("first_f_fstart", 32'(vga_f.frame_start), 0);
      end
      if (n == 6 * FHT) begin
        // Line wrap from (1343,5) lands on (0,6) with both horizontal strobes low.
        check("lwrap_h", 32'(vga_f.hcount), 0);
        check("lwrap_v", 32'(vga_f.vcount), 6);
        check("lwrap_hblnk", 32'(vga_f.hblnk), 0);
        check("lwrap_hsync", 32'(vga_f.hsync), 0);
      end
    end
    check("s_pulses", 32'(pulses), 3);

    // Mid-frame asynchronous reset at (5,4) of dut_s.
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      @(negedge clk);
      if (vga_s.hcount == 11'd5 && vga_s.vcount == 11'd4) found = 1'b1;
    end
    check("mid_wait", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First pulse exactly one frame after release, never earlier.
    for (int n = 1; n <= FRAME + 1; n++) begin
      @(negedge clk);
      check("mid_fstart", 32'(vga_s.frame_start), 32'(n == FRAME));
      if (n == FRAME) check("mid_fcnt", 32'(vga_s.frame_cnt), 1);
    end

    // Preload the frame counter to its maximum; the next wrap rolls it to zero.
    force dut_s.r_frame_cnt = 16'hFFFF;
    #1 release dut_s.r_frame_cnt;
    check("pre_fcnt", 32'(vga_s.frame_cnt), 32'hFFFF);
    for (int n = FRAME + 2; n <= 2 * FRAME; n++) begin
      @(negedge clk);
      check("roll_fstart", 32'(vga_s.frame_start), 32'(n == 2 * FRAME));
      check("roll_fcnt", 32'(vga_s.frame_cnt), (n == 2 * FRAME) ? 32'h0 : 32'hFFFF);
    end
    @(negedge clk);
    check("roll_pulse_end", 32'(vga_s.frame_start), 0);
    check("roll_hold", 32'(vga_s.frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
